// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory dump controller: FSM encoding, default dump window
// base and word size.
package dmem_pkg;

  localparam logic [1:0] StCore  = 2'd0;
  localparam logic [1:0] StDump  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [31:0] DUMP_BASE_DEFAULT = 32'h1001_0000;
  localparam int unsigned WORD_BYTES        = 4;

  // Counter width able to hold indices 0..words-1, at least one bit.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dmem_dump_ctrl_if.sv
// Bus bundle around the dump controller: core request port, memory port, sink port and dump
// handshake. The controller uses the slave modport; its environment uses master.
interface dmem_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_done;
  logic              mem_cs;
  logic              mem_rd;
  logic              mem_wr_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              sink_en;
  logic [DATA_W-1:0] sink_data;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, dump_start, mem_rdata,
    output core_rdata, core_stall, dump_busy, dump_done,
    output mem_cs, mem_rd, mem_wr_n, mem_addr, mem_wdata, sink_en, sink_data
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, dump_start, mem_rdata,
    input  core_rdata, core_stall, dump_busy, dump_done,
    input  mem_cs, mem_rd, mem_wr_n, mem_addr, mem_wdata, sink_en, sink_data
  );

endinterface

// File: rtl/dump_addr_gen.sv
// Dump word index counter: produces the byte address of the current dump word and flags the
// last index of the window.
module dump_addr_gen
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] DUMP_BASE  = ADDR_W'(DUMP_BASE_DEFAULT),
  parameter int unsigned       DUMP_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int unsigned      IDX_W    = idx_width(DUMP_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

  logic [IDX_W-1:0] r_idx;

  // Holds at the last index so the counter never wraps inside a burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_advance && !o_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_last = (r_idx == LAST_IDX);
  assign o_addr = DUMP_BASE + ADDR_W'(r_idx) * ADDR_W'(WORD_BYTES);

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-memory ownership controller: passes core accesses through, and on dump_start streams
// a fixed memory window to the sink. Optional macro DMEM_DUMP_SKIP_ZERO_EN drops zero words.
module dmem_dump_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DUMP_BASE  = ADDR_W'(DUMP_BASE_DEFAULT),
  parameter int unsigned       DUMP_WORDS = 256
) (
  input logic               clk,
  input logic               rst,
  dmem_dump_ctrl_if.slave   bus
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_d;
  logic              r_rd_vld;
  logic              w_clear;
  logic              w_advance;
  logic              w_last;
  logic [ADDR_W-1:0] w_dump_addr;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_word_ok;

  assign w_clear   = (r_state == StCore) && bus.dump_start;
  assign w_advance = (r_state == StDump);

  dump_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_WORDS(DUMP_WORDS)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_advance(w_advance),
    .o_addr   (w_dump_addr),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StCore:  if (bus.dump_start) w_state_d = StDump;
      StDump:  if (w_last) w_state_d = StFlush;
      StFlush: w_state_d = StCore;
      default: w_state_d = StCore;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StCore;
      r_rd_vld <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rd_vld <= (r_state == StDump);
    end
  end

  // Core owns the port in CORE; a held core write during a dump never reaches memory.
  always_comb begin
    bus.mem_cs     = 1'b1;
    bus.mem_rd     = bus.core_rd;
    bus.mem_wr_n   = ~bus.core_wr;
    bus.mem_addr   = bus.core_addr;
    bus.mem_wdata  = bus.core_wdata;
    bus.core_rdata = bus.mem_rdata;
    bus.core_stall = 1'b0;
    if (r_state == StDump) begin
      bus.mem_rd     = 1'b1;
      bus.mem_wr_n   = 1'b1;
      bus.mem_addr   = w_dump_addr;
      bus.core_rdata = '0;
      bus.core_stall = 1'b1;
    end else if (r_state == StFlush) begin
      bus.mem_rd     = 1'b0;
      bus.mem_wr_n   = 1'b1;
      bus.mem_addr   = w_dump_addr;
      bus.core_rdata = '0;
      bus.core_stall = 1'b1;
    end
  end

  assign w_rd_word = bus.mem_rdata;

`ifdef DMEM_DUMP_SKIP_ZERO_EN
  assign w_word_ok = |w_rd_word;
`else
  assign w_word_ok = 1'b1;
`endif

  assign bus.sink_en   = r_rd_vld && w_word_ok;
  assign bus.sink_data = w_rd_word;
  assign bus.dump_busy = (r_state == StDump) || (r_state == StFlush);
  assign bus.dump_done = (r_state == StFlush);

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Self-checking bench for dmem_dump_ctrl: behavioural memory, shadow copy of the dump window
// and cycle-exact expectations derived from the start edge.
module tb_dmem_dump_ctrl;

  localparam int unsigned N    = 256;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_dump_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_dump_ctrl #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DUMP_BASE (BASE),
    .DUMP_WORDS(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous memory covering the dump window, read data one cycle after mem_rd.
  logic [31:0] mem_arr [0:N-1];
  logic [31:0] shadow  [0:N-1];
  int n_checks = 0;
  int n_errors = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * N);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_cs && !bus.mem_wr_n && in_win(bus.mem_addr))
      mem_arr[(bus.mem_addr - BASE) >> 2] <= bus.mem_wdata;
    if (bus.mem_cs && bus.mem_rd)
      bus.mem_rdata <= in_win(bus.mem_addr) ? mem_arr[(bus.mem_addr - BASE) >> 2] : 32'h0;
  end

  function automatic bit keep(input logic [31:0] w);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    return w != 32'h0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fill the window through the core port, mirroring into the shadow copy.
  task automatic load_window(input int mode);
    int nz;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       shadow[i] = 32'(i + 1);
        1:       shadow[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        default: shadow[i] = 32'h0;
      endcase
    end
    if (mode == 2) begin
      nz = 0;
      while (nz < 10) begin
        int k;
        k = $urandom_range(0, N - 1);
        if (shadow[k] == 32'h0) begin
          shadow[k] = $urandom | 32'h1;
          nz++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.core_wr    = 1'b1;
      bus.core_addr  = BASE + 32'(4 * i);
      bus.core_wdata = shadow[i];
    end
    @(negedge clk);
    bus.core_wr = 1'b0;
  endtask

  task automatic run_dump(input bit collide, input bit hold_wr, input bit extra_start,
                          input int abort_at);
    int  strobes;
    int  exp_strobes;
    bit  exp_sink;
    strobes     = 0;
    exp_strobes = 0;
    @(negedge clk);
    bus.dump_start = 1'b1;
    if (collide) begin
      bus.core_wr    = 1'b1;
      bus.core_addr  = BASE;
      bus.core_wdata = 32'h55;
      shadow[0]      = 32'h55;
    end
    for (int i = 0; i < N; i++) if (keep(shadow[i])) exp_strobes++;
    for (int c = 1; c <= int'(N) + 2; c++) begin
      @(negedge clk);
      check_eq("mem_rd", 32'(bus.mem_rd), 32'(c <= int'(N)));
      if (c <= int'(N)) check_eq("mem_addr", bus.mem_addr, BASE + 32'(4 * (c - 1)));
      if (c <= int'(N) + 1) begin
        check_eq("mem_wr_n", 32'(bus.mem_wr_n), 32'd1);
        check_eq("core_rdata", bus.core_rdata, 32'h0);
      end
      check_eq("core_stall", 32'(bus.core_stall), 32'(c <= int'(N) + 1));
      check_eq("dump_busy", 32'(bus.dump_busy), 32'(c <= int'(N) + 1));
      exp_sink = 1'b0;
      if (c >= 2 && c <= int'(N) + 1) exp_sink = keep(shadow[c - 2]);
      check_eq("sink_en", 32'(bus.sink_en), 32'(exp_sink));
      if (exp_sink) check_eq("sink_data", bus.sink_data, shadow[c - 2]);
      if (bus.sink_en) strobes++;
      check_eq("dump_done", 32'(bus.dump_done), 32'(c == int'(N) + 1));
      if (c == 1) begin
        bus.dump_start = 1'b0;
        bus.core_wr    = hold_wr;
        bus.core_addr  = BASE + 32'd800;
        bus.core_wdata = 32'hBAD0_BAD0;
      end
      if (extra_start && c == 50) bus.dump_start = 1'b1;
      if (c == 51) bus.dump_start = 1'b0;
      if (c == int'(N) + 1) bus.core_wr = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_sink_en", 32'(bus.sink_en), 32'd0);
        check_eq("rst_done", 32'(bus.dump_done), 32'd0);
        check_eq("rst_busy", 32'(bus.dump_busy), 32'd0);
        check_eq("rst_stall", 32'(bus.core_stall), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("post_rst_done", 32'(bus.dump_done), 32'd0);
          check_eq("post_rst_busy", 32'(bus.dump_busy), 32'd0);
          check_eq("post_rst_stall", 32'(bus.core_stall), 32'd0);
          check_eq("post_rst_sink_en", 32'(bus.sink_en), 32'd0);
        end
        return;
      end
    end
    check_eq("strobe_count", 32'(strobes), 32'(exp_strobes));
  endtask

  initial begin
    bus.core_rd    = 1'b0;
    bus.core_wr    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.dump_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", 32'(bus.dump_busy), 32'd0);
    check_eq("reset_done", 32'(bus.dump_done), 32'd0);
    check_eq("reset_sink_en", 32'(bus.sink_en), 32'd0);
    check_eq("reset_stall", 32'(bus.core_stall), 32'd0);
    check_eq("reset_cs", 32'(bus.mem_cs), 32'd1);
    rst = 1'b0;

    // Core pass-through write then read.
    @(negedge clk);
    bus.core_wr    = 1'b1;
    bus.core_addr  = 32'h1001_0010;
    bus.core_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("pt_wr_n", 32'(bus.mem_wr_n), 32'd0);
    check_eq("pt_addr", bus.mem_addr, 32'h1001_0010);
    check_eq("pt_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check_eq("pt_stall_wr", 32'(bus.core_stall), 32'd0);
    @(negedge clk);
    bus.core_wr = 1'b0;
    bus.core_rd = 1'b1;
    #1;
    check_eq("pt_rd", 32'(bus.mem_rd), 32'd1);
    check_eq("pt_wr_n_idle", 32'(bus.mem_wr_n), 32'd1);
    @(negedge clk);
    bus.core_rd = 1'b0;
    check_eq("pt_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    check_eq("pt_stall_rd", 32'(bus.core_stall), 32'd0);

    // Full dump of 1..N with an ignored start mid-burst.
    load_window(0);
    run_dump(1'b0, 1'b0, 1'b1, -1);

    // Random window, core holds a write to the window throughout the dump.
    load_window(1);
    run_dump(1'b0, 1'b1, 1'b0, -1);

    // Start collides with a core write to the base; reset while word 100 is at the sink.
    load_window(1);
    run_dump(1'b1, 1'b0, 1'b0, 102);

    // Sparse window of ten nonzero words, dumped again after the abort.
    load_window(2);
    run_dump(1'b0, 1'b0, 1'b0, -1);
    run_dump(1'b0, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
